seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan_pkg.sv | 21 ++
 rtl/seg7_scan_hex_lut.sv | 11 +
 rtl/seg7_scan.sv | 162 ++++++++++++++++
 tb/tb_seg7_scan.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: the blank
// pattern, the hex glyph table and a width helper for the scan counters.
package seg7_scan_pkg;

    // All segments off; outputs are active-low.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Hex glyphs, bit order g..a (a = bit 0), active-low.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_hex_lut.sv
// Combinational hex nibble to active-low segment pattern lookup.
module seg7_hex_lut
    import seg7_scan_pkg::*;
(
    input  logic [3:0] I,
    output logic [6:0] O_seg
);

    assign O_seg = HEX_SEG[I];

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed seven-segment scanner with frame-synchronous data
// latching, per-digit enables, leading-zero blanking and ghost suppression
// at the start of every digit slot.
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int SCAN_DIV = 100000,
    parameter int BLANK    = 16
)
(
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic [4*N_DIGITS-1:0] I_data,
    input  logic [N_DIGITS-1:0]   I_dp,
    input  logic [N_DIGITS-1:0]   I_en,
    input  logic                  I_load,
    input  logic                  I_lzb,
    output logic [6:0]            O_seg,
    output logic                  O_dp,
    output logic [N_DIGITS-1:0]   O_led,
    output logic                  O_frame
);

    localparam int CW = cntWidth(SCAN_DIV);
    localparam int IW = cntWidth(N_DIGITS);
    localparam int DW = 4 * N_DIGITS;

    localparam logic [CW-1:0]       CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]       CNT_BLANK = CW'(BLANK);
    localparam logic [IW-1:0]       IDX_LAST  = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] LED_ONE   = N_DIGITS'(1);

    logic [CW-1:0]       slotCnt_q;
    logic [IW-1:0]       digitIdx_q;
    logic                slotEnd;
    logic                frameWrap;

    logic [DW-1:0]       pendData_q;
    logic [N_DIGITS-1:0] pendDp_q;
    logic [N_DIGITS-1:0] pendEn_q;
    logic                pendFlag_q;

    logic [DW-1:0]       dispData_q;
    logic [N_DIGITS-1:0] dispDp_q;
    logic [N_DIGITS-1:0] dispEn_q;

    logic [3:0]          curNib;
    logic                curDp;
    logic                curEn;
    logic                upperZero;
    logic [6:0]          lutSeg;

    logic [6:0]          seg_d;
    logic                dp_d;
    logic [N_DIGITS-1:0] led_d;
    logic                frame_d;

    logic [6:0]          seg_q;
    logic                dp_q;
    logic [N_DIGITS-1:0] led_q;
    logic                frame_q;

    assign slotEnd   = (slotCnt_q == CNT_LAST);
    assign frameWrap = slotEnd && (digitIdx_q == IDX_LAST);

    // Slot counter and digit index: the index steps once per full slot.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            slotCnt_q  <= '0;
            digitIdx_q <= '0;
        end else begin
            slotCnt_q <= slotEnd ? '0 : slotCnt_q + CW'(1);
            if (slotEnd) begin
                digitIdx_q <= frameWrap ? '0 : digitIdx_q + IW'(1);
            end
        end
    end

    // Loads land in a pending buffer and only reach the display at a frame
    // wrap; a load on the wrap edge itself stays pending for the next frame.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            pendData_q <= '0;
            pendDp_q   <= '0;
            pendEn_q   <= '0;
            pendFlag_q <= 1'b0;
            dispData_q <= '0;
            dispDp_q   <= '0;
            dispEn_q   <= '0;
        end else begin
            if (frameWrap && pendFlag_q) begin
                dispData_q <= pendData_q;
                dispDp_q   <= pendDp_q;
                dispEn_q   <= pendEn_q;
            end
            if (I_load) begin
                pendData_q <= I_data;
                pendDp_q   <= I_dp;
                pendEn_q   <= I_en;
                pendFlag_q <= 1'b1;
            end else if (frameWrap) begin
                pendFlag_q <= 1'b0;
            end
        end
    end

    // Pick the current digit and find whether it and every digit above it are zero.
    always_comb begin
        curNib    = 4'h0;
        curDp     = 1'b0;
        curEn     = 1'b0;
        upperZero = 1'b1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (IW'(k) == digitIdx_q) begin
                curNib = dispData_q[4*k +: 4];
                curDp  = dispDp_q[k];
                curEn  = dispEn_q[k];
            end
            if ((IW'(k) >= digitIdx_q) && (dispData_q[4*k +: 4] != 4'h0)) begin
                upperZero = 1'b0;
            end
        end
    end

    seg7_hex_lut u_lut (
        .I     (curNib),
        .O_seg (lutSeg)
    );

    // Form next outputs: disabled or leading-zero digits go fully dark,
    // and the anode stays off during the ghost-suppression window.
    always_comb begin
        logic digitBlank;
        digitBlank = !curEn || (I_lzb && (digitIdx_q != '0) && upperZero);
        seg_d      = digitBlank ? SEG_BLANK : lutSeg;
        dp_d       = digitBlank ? 1'b1 : !curDp;
        led_d      = (digitBlank || (slotCnt_q < CNT_BLANK)) ? '1 : ~(LED_ONE << digitIdx_q);
        frame_d    = (slotCnt_q == '0) && (digitIdx_q == '0);
    end

    // Register outputs so they trail the scan state by one cycle.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            led_q   <= '1;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            led_q   <= led_d;
            frame_q <= frame_d;
        end
    end

    assign O_seg   = seg_q;
    assign O_dp    = dp_q;
    assign O_led   = led_q;
    assign O_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan (4 digits, 8 cycles per slot, 2 blank
// cycles) against a cycle-count based reference model.
module tb_seg7_scan;

    localparam int ND = 4;
    localparam int SD = 8;
    localparam int BL = 2;
    localparam int FRAME = ND * SD;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic [15:0] data = 16'h0;
    logic [3:0]  dp   = 4'h0;
    logic [3:0]  en   = 4'h0;
    logic        load = 1'b0;
    logic        lzb  = 1'b0;

    logic [6:0]  oSeg;
    logic        oDp;
    logic [3:0]  oLed;
    logic        oFrame;

    int errors = 0;
    int checks = 0;

    logic [6:0] hexTab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int          cyc;
    logic [15:0] mData, pData;
    logic [3:0]  mDp, mEn, pDp, pEn;
    bit          pFlag;

    seg7_scan #(
        .N_DIGITS (ND),
        .SCAN_DIV (SD),
        .BLANK    (BL)
    ) dut (
        .I_clk   (clk),
        .I_rst   (rst),
        .I_data  (data),
        .I_dp    (dp),
        .I_en    (en),
        .I_load  (load),
        .I_lzb   (lzb),
        .O_seg   (oSeg),
        .O_dp    (oDp),
        .O_led   (oLed),
        .O_frame (oFrame)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, act, exp);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_seg"}, {9'h0, oSeg}, 16'h007F);
        checkOutput({tag, "_dp"}, {15'h0, oDp}, 16'h0001);
        checkOutput({tag, "_led"}, {12'h0, oLed}, 16'h000F);
        checkOutput({tag, "_frame"}, {15'h0, oFrame}, 16'h0000);
    endtask

    task automatic modelReset();
        cyc   = 0;
        mData = '0; mDp = '0; mEn = '0;
        pData = '0; pDp = '0; pEn = '0;
        pFlag = 1'b0;
    endtask

    // One clock: predict outputs from the pre-edge scan position, advance model, compare.
    task automatic stepCycle();
        int          digit, cnt;
        logic [15:0] upper;
        logic        blank;
        logic [6:0]  eSeg;
        logic        eDp;
        logic [3:0]  eLed;
        logic        eFrame;
        logic        wrap;
        @(posedge clk);
        digit  = (cyc / SD) % ND;
        cnt    = cyc % SD;
        upper  = mData >> (4 * digit);
        blank  = !mEn[digit] || (lzb && digit > 0 && upper == 16'h0);
        eSeg   = blank ? 7'h7F : hexTab[upper[3:0]];
        eDp    = blank ? 1'b1 : !mDp[digit];
        eLed   = (blank || cnt < BL) ? 4'hF : (4'hF & ~(4'b0001 << digit));
        eFrame = (cyc % FRAME) == 0;
        wrap   = (cyc % FRAME) == FRAME - 1;
        if (wrap && pFlag) begin
            mData = pData; mDp = pDp; mEn = pEn;
        end
        if (load) begin
            pData = data; pDp = dp; pEn = en; pFlag = 1'b1;
        end else if (wrap) begin
            pFlag = 1'b0;
        end
        #1;
        checkOutput("seg", {9'h0, oSeg}, {9'h0, eSeg});
        checkOutput("dp", {15'h0, oDp}, {15'h0, eDp});
        checkOutput("led", {12'h0, oLed}, {12'h0, eLed});
        checkOutput("frame", {15'h0, oFrame}, {15'h0, eFrame});
        cyc++;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    // Step until the next edge's pre-edge frame phase equals p (bounded by one frame).
    task automatic waitPhase(input int p);
        for (int i = 0; i < FRAME && (cyc % FRAME) != p; i++) stepCycle();
    endtask

    // Single-cycle load, then scramble the data bus to show only the load edge counts.
    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
        data = d; dp = p; en = e; load = 1'b1;
        stepCycle();
        load = 1'b0;
        data = 16'($urandom); dp = 4'($urandom); en = 4'($urandom);
    endtask

    initial begin
        logic [15:0] mask;
        modelReset();
        #12;
        checkResetOutputs("reset_initial");
        @(posedge clk); #1;
        checkResetOutputs("reset_held");
        #2 rst = 1'b0;

        // Empty display: everything dark, frame pulse every 32 cycles.
        runCycles(70);

        // Mid-frame load only appears after the next wrap.
        waitPhase(10);
        applyStimulus(16'h1234, 4'b0000, 4'b1111);
        runCycles(60);

        // Leading-zero blanking on and off.
        lzb = 1'b1;
        applyStimulus(16'h00A0, 4'b1111, 4'b1111);
        runCycles(64);
        lzb = 1'b0;
        runCycles(32);

        // Two loads in one frame: last wins.
        waitPhase(4);
        applyStimulus(16'h1111, 4'b0000, 4'b1111);
        runCycles(5);
        applyStimulus(16'h2222, 4'b0000, 4'b1111);
        runCycles(60);

        // Decimal point requested on a disabled digit.
        applyStimulus(16'h5678, 4'b0100, 4'b1011);
        runCycles(64);

        // Load exactly on the wrap edge shows one frame later.
        waitPhase(FRAME - 1);
        applyStimulus(16'h9ABC, 4'b0011, 4'b1111);
        runCycles(70);

        // Random loads, enables and live blanking-mode changes.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0: mask = 16'hFFFF;
                    1: mask = 16'h0FFF;
                    2: mask = 16'h00FF;
                    default: mask = 16'h000F;
                endcase
                data = 16'($urandom) & mask;
                dp   = 4'($urandom);
                en   = 4'($urandom);
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            if ($urandom_range(0, 19) == 0) lzb = ~lzb;
            stepCycle();
        end
        load = 1'b0;
        lzb  = 1'b0;

        // Reset in slot 2 with a load pending: everything clears, nothing survives.
        applyStimulus(16'hDEF0, 4'b1010, 4'b1111);
        runCycles(40);
        waitPhase(17);
        applyStimulus(16'h4321, 4'b0001, 4'b1111);
        runCycles(2);
        #2 rst = 1'b1;
        #1 checkResetOutputs("reset_async");
        modelReset();
        @(posedge clk); #1;
        checkResetOutputs("reset_hold2");
        #2 rst = 1'b0;
        runCycles(70);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
